// File: rtl/getir_pkg.sv
// Shared types and constants for the instruction-fetch / program-load stage.
package getir_pkg;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        YUKLE = 2'd1,
        CALIS = 2'd2,
        HATA  = 2'd3
    } durum_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int BAYT_IDX_W = 2;

endpackage

// File: rtl/kelime_birlestirici.sv
// Little-endian byte-to-word assembler: byte k lands in bits [8k+7:8k]; a flush
// emits a pending partial word with zero upper bytes. kelime_gecerli_o pulses per word.
module kelime_birlestirici
    import getir_pkg::*;
(
    input  logic        saat,
    input  logic        reset,
    input  logic        bayt_al_i,
    input  logic [7:0]  bayt_i,
    input  logic        bosalt_i,
    output logic [31:0] kelime_o,
    output logic        kelime_gecerli_o
);

    logic [BAYT_IDX_W-1:0] sayac_q, sayac_d;
    logic [31:0]           kelime_q, kelime_d;
    logic [31:0]           birlesik;
    logic                  dolu;
    logic                  bekleyen;

    always_comb begin
        birlesik = kelime_q;
        for (int k = 0; k < 4; k++) begin
            if (bayt_al_i && (sayac_q == BAYT_IDX_W'(k))) begin
                birlesik[8*k +: 8] = bayt_i;
            end
        end
        dolu             = bayt_al_i && (sayac_q == BAYT_IDX_W'(3));
        bekleyen         = bayt_al_i || (sayac_q != '0);
        kelime_gecerli_o = dolu || (bosalt_i && bekleyen);
        kelime_o         = birlesik;
        // Clearing after each word is what makes the flush zero-padded.
        kelime_d = kelime_gecerli_o ? '0 : birlesik;
        sayac_d  = kelime_gecerli_o ? '0 : sayac_q + BAYT_IDX_W'(bayt_al_i);
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            sayac_q  <= '0;
            kelime_q <= '0;
        end else begin
            sayac_q  <= sayac_d;
            kelime_q <= kelime_d;
        end
    end

endmodule

// File: rtl/buyruk_getirici.sv
// Program loader + instruction fetch in front of the single-cycle core.
// Optional executed-instruction counter enabled by macro BUYRUK_SAYACI_EN.
module buyruk_getirici
    import getir_pkg::*;
#(
    parameter int DERINLIK = 256,
    parameter int ADRES_W  = $clog2(DERINLIK)
) (
    input  logic               saat,
    input  logic               reset,
    input  logic               yukle_gecerli,
    input  logic [7:0]         yukle_veri,
    output logic               yukle_hazir,
    input  logic               yukle_bitti,
    input  logic [31:0]        ps,
    output logic [31:0]        buyruk,
    output logic               cekirdek_reset,
    output logic [ADRES_W:0]   yuklenen,
    output logic               tasma,
    output logic               hata,
    output logic [31:0]        komut_sayisi,
    output durum_e             durum
);

    localparam logic [ADRES_W:0] DOLU_SINIR = (ADRES_W+1)'(DERINLIK);

    durum_e             durum_q, durum_d;
    logic [ADRES_W:0]   yuklenen_q, yuklenen_d;
    logic               tasma_q, tasma_d;
    logic               hata_q, hata_d;
    logic               cekirdek_reset_q, cekirdek_reset_d;

    logic [31:0]        ram [DERINLIK];

    logic               yukleniyor;
    logic               ram_dolu;
    logic               bayt_al;
    logic               bosalt;
    logic [31:0]        kelime;
    logic               kelime_gecerli;
    logic [ADRES_W-1:0] kelime_idx;
    logic               gecerli_adres;
    logic               getir_gecerli;

    // Load handshake: a byte transfers on a rising edge where yukle_gecerli and
    // yukle_hazir are both high; a byte offered while the RAM is full is dropped.
    assign yukleniyor  = (durum_q == YUKLE);
    assign ram_dolu    = (yuklenen_q == DOLU_SINIR);
    assign yukle_hazir = yukleniyor && !ram_dolu;
    assign bayt_al     = yukle_gecerli && yukle_hazir;
    assign bosalt      = yukleniyor && yukle_bitti;

    kelime_birlestirici u_birlestirici (
        .saat             (saat),
        .reset            (reset),
        .bayt_al_i        (bayt_al),
        .bayt_i           (yukle_veri),
        .bosalt_i         (bosalt),
        .kelime_o         (kelime),
        .kelime_gecerli_o (kelime_gecerli)
    );

    assign kelime_idx    = ps[ADRES_W+1:2];
    assign gecerli_adres = (ps[1:0] == 2'b00) &&
                           (ps[31:ADRES_W+2] == '0) &&
                           ({1'b0, kelime_idx} < yuklenen_q);
    assign getir_gecerli = (durum_q == CALIS) && gecerli_adres;
    assign buyruk        = getir_gecerli ? ram[kelime_idx] : NOP;

    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOS:     durum_d = YUKLE;
            YUKLE:   if (yukle_bitti) durum_d = CALIS;
            CALIS:   if (!gecerli_adres) durum_d = HATA;
            HATA:    durum_d = HATA;
            default: durum_d = BOS;
        endcase
        yuklenen_d       = yuklenen_q + (ADRES_W+1)'(kelime_gecerli);
        tasma_d          = tasma_q || (yukleniyor && ram_dolu && yukle_gecerli);
        hata_d           = (durum_d == HATA);
        cekirdek_reset_d = (durum_d != CALIS);
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q          <= BOS;
            yuklenen_q       <= '0;
            tasma_q          <= 1'b0;
            hata_q           <= 1'b0;
            cekirdek_reset_q <= 1'b1;
        end else begin
            durum_q          <= durum_d;
            yuklenen_q       <= yuklenen_d;
            tasma_q          <= tasma_d;
            hata_q           <= hata_d;
            cekirdek_reset_q <= cekirdek_reset_d;
        end
    end

    // Contents survive reset; yuklenen=0 makes every old word unreachable.
    always_ff @(posedge saat) begin
        if (kelime_gecerli) begin
            ram[yuklenen_q[ADRES_W-1:0]] <= kelime;
        end
    end

`ifdef BUYRUK_SAYACI_EN
    logic [31:0] sayac_q;

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            sayac_q <= '0;
        end else if (getir_gecerli) begin
            sayac_q <= sayac_q + 32'd1;
        end
    end

    assign komut_sayisi = sayac_q;
`else
    assign komut_sayisi = '0;
`endif

    assign yuklenen       = yuklenen_q;
    assign tasma          = tasma_q;
    assign hata           = hata_q;
    assign cekirdek_reset = cekirdek_reset_q;
    assign durum          = durum_q;

endmodule
